mcu_spi_arbiter: RTL and testbench

Shares the core's single MCU SPI link (mcu_sclk/csn/mosi in, mcu_miso/intn out) between the onboard BL616 port and the external M0S/PiPico PMOD port. It replaces the sticky one-shot external select with frame-boundary arbitration, a post-frame guard interval, a stuck-chip-select watchdog and collision counting. It sits in the board toplevel between the pin-level SPI signals and misterynano.

---
 rtl/mcu_spi_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mcu_spi_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_spi_arbiter.sv
// Frame-boundary arbiter sharing the core's MCU SPI link between the onboard BL616
// port and the external PMOD port, with post-frame guard, stuck-csn watchdog and collision count.
module mcu_spi_arbiter #(
    parameter bit          STICKY_EXT   = 1'b1,
    parameter int unsigned GUARD        = 4,
    parameter logic [21:0] BUSY_TIMEOUT = 22'd3200000
) (
    input  logic       clk32,
    input  logic       por,
    input  logic       int_sclk,
    input  logic       int_csn,
    input  logic       int_mosi,
    output logic       int_miso,
    input  logic       ext_sclk,
    input  logic       ext_csn,
    input  logic       ext_mosi,
    output logic       ext_miso,
    output logic       mcu_sclk,
    output logic       mcu_csn,
    output logic       mcu_mosi,
    input  logic       mcu_miso,
    input  logic       mcu_intn,
    output logic       int_intn,
    output logic       ext_intn,
    output logic       ext_sel,
    output logic       locked_ext,
    output logic [7:0] collisions
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GUARD, S_LOCKOUT} state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD - 1);

    state_t      state_q, state_d;
    logic [1:0]  int_sync_q, int_sync_d;
    logic [1:0]  ext_sync_q, ext_sync_d;
    logic        int_prev_q, int_prev_d;
    logic        ext_prev_q, ext_prev_d;
    logic        sel_q, sel_d;
    logic        locked_q, locked_d;
    logic        pend_q, pend_d;
    logic [3:0]  guard_q, guard_d;
    logic [21:0] wd_q, wd_d;
    logic [7:0]  coll_q, coll_d;

    logic int_fall, int_rise, ext_fall, ext_rise;
    logic own_fall, own_rise, own_low, oth_fall, coll_hit;

    assign int_fall = int_prev_q & ~int_sync_q[1];
    assign int_rise = ~int_prev_q & int_sync_q[1];
    assign ext_fall = ext_prev_q & ~ext_sync_q[1];
    assign ext_rise = ~ext_prev_q & ext_sync_q[1];

    assign own_fall = sel_q ? ext_fall : int_fall;
    assign own_rise = sel_q ? ext_rise : int_rise;
    assign own_low  = sel_q ? ~ext_sync_q[1] : ~int_sync_q[1];
    // Once locked the owner is always ext, so masking here silences the int port entirely.
    assign oth_fall = (sel_q ? int_fall : ext_fall) & ~locked_q;

    always_comb begin
        int_sync_d = {int_sync_q[0], int_csn};
        ext_sync_d = {ext_sync_q[0], ext_csn};
        int_prev_d = int_sync_q[1];
        ext_prev_d = ext_sync_q[1];
        state_d    = state_q;
        sel_d      = sel_q;
        locked_d   = locked_q;
        pend_d     = pend_q;
        guard_d    = guard_q;
        wd_d       = wd_q;
        coll_d     = coll_q;
        coll_hit   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (own_fall) begin
                    state_d  = S_BUSY;
                    wd_d     = '0;
                    coll_hit = oth_fall;
                end else if (oth_fall) begin
                    sel_d   = ~sel_q;
                    state_d = S_BUSY;
                    wd_d    = '0;
                end
            end
            S_BUSY: begin
                wd_d     = wd_q + 22'd1;
                coll_hit = oth_fall;
                if (own_rise) begin
                    state_d = S_GUARD;
                    guard_d = GUARD_LOAD;
                end else if (BUSY_TIMEOUT != 22'd0 && wd_q == BUSY_TIMEOUT - 22'd1) begin
                    state_d = S_LOCKOUT;
                end
            end
            S_GUARD: begin
                coll_hit = oth_fall;
                pend_d   = pend_q | own_fall;
                if (guard_q == 4'd0) begin
                    pend_d = 1'b0;
                    if ((pend_q | own_fall) && own_low) begin
                        state_d = S_BUSY;
                        wd_d    = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    guard_d = guard_q - 4'd1;
                end
            end
            S_LOCKOUT: begin
                coll_hit = oth_fall;
                if (own_rise) begin
                    state_d = S_GUARD;
                    guard_d = GUARD_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (coll_hit && coll_q != 8'hFF) begin
            coll_d = coll_q + 8'd1;
        end
        if (STICKY_EXT && state_d == S_BUSY && sel_d) begin
            locked_d = 1'b1;
        end
    end

    always_ff @(posedge clk32 or posedge por) begin
        if (por) begin
            state_q    <= S_IDLE;
            int_sync_q <= 2'b11;
            ext_sync_q <= 2'b11;
            int_prev_q <= 1'b1;
            ext_prev_q <= 1'b1;
            sel_q      <= 1'b0;
            locked_q   <= 1'b0;
            pend_q     <= 1'b0;
            guard_q    <= '0;
            wd_q       <= '0;
            coll_q     <= '0;
        end else begin
            state_q    <= state_d;
            int_sync_q <= int_sync_d;
            ext_sync_q <= ext_sync_d;
            int_prev_q <= int_prev_d;
            ext_prev_q <= ext_prev_d;
            sel_q      <= sel_d;
            locked_q   <= locked_d;
            pend_q     <= pend_d;
            guard_q    <= guard_d;
            wd_q       <= wd_d;
            coll_q     <= coll_d;
        end
    end

    // Data paths stay combinational from the raw pins; only the owner choice is registered.
    assign mcu_sclk   = sel_q ? ext_sclk : int_sclk;
    assign mcu_mosi   = sel_q ? ext_mosi : int_mosi;
    assign mcu_csn    = (state_q == S_IDLE || state_q == S_BUSY) ? (sel_q ? ext_csn : int_csn) : 1'b1;
    assign int_miso   = sel_q ? 1'b1 : mcu_miso;
    assign ext_miso   = sel_q ? mcu_miso : 1'b1;
    assign int_intn   = locked_q ? 1'b1 : mcu_intn;
    assign ext_intn   = mcu_intn;
    assign ext_sel    = sel_q;
    assign locked_ext = locked_q;
    assign collisions = coll_q;

endmodule

// File: tb/tb_mcu_spi_arbiter.sv
// Self-checking bench for mcu_spi_arbiter: two instances (sticky and non-sticky) share
// random SPI traffic and are compared every cycle against a frame-level reference model.
module tb_mcu_spi_arbiter;

   localparam int GuardCycles   = 4;
   localparam int TimeoutCycles = 100;

   logic clk32 = 1'b0;
   logic por;
   logic intSclk, intCsn, intMosi;
   logic extSclk, extCsn, extMosi;
   logic mcuMiso, mcuIntn;

   logic       intMiso   [2];
   logic       extMiso   [2];
   logic       mcuSclk   [2];
   logic       mcuCsn    [2];
   logic       mcuMosi   [2];
   logic       intIntn   [2];
   logic       extIntn   [2];
   logic       extSel    [2];
   logic       lockedExt [2];
   logic [7:0] collisions [2];

   // Reference model state per instance (index 0 = sticky, 1 = non-sticky)
   string mMode      [2];
   bit    mSel       [2];
   bit    mLocked    [2];
   bit    mPending   [2];
   int    mColl      [2];
   int    mGuardLeft [2];
   int    mBusyEdges [2];

   // Raw csn as sampled on the last three clock edges, newest first
   bit intHist [3];
   bit extHist [3];

   int total = 0;
   int bad   = 0;

   bit randomMode;
   int lowLeft [2];
   int gapLeft [2];

   // 32 MHz-ish free-running clock; the absolute period does not matter to the checks
   always #5 clk32 = ~clk32;

   // Two instances: one with the sticky external lock, one without, both with a short watchdog
   for (genvar g = 0; g < 2; g++) begin : gDut
      mcu_spi_arbiter #(
         .STICKY_EXT   ((g == 0) ? 1'b1 : 1'b0),
         .GUARD        (GuardCycles),
         .BUSY_TIMEOUT (22'(TimeoutCycles))
      ) dut (
         .clk32      (clk32),
         .por        (por),
         .int_sclk   (intSclk),
         .int_csn    (intCsn),
         .int_mosi   (intMosi),
         .int_miso   (intMiso[g]),
         .ext_sclk   (extSclk),
         .ext_csn    (extCsn),
         .ext_mosi   (extMosi),
         .ext_miso   (extMiso[g]),
         .mcu_sclk   (mcuSclk[g]),
         .mcu_csn    (mcuCsn[g]),
         .mcu_mosi   (mcuMosi[g]),
         .mcu_miso   (mcuMiso),
         .mcu_intn   (mcuIntn),
         .int_intn   (intIntn[g]),
         .ext_intn   (extIntn[g]),
         .ext_sel    (extSel[g]),
         .locked_ext (lockedExt[g]),
         .collisions (collisions[g])
      );
   end

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Power-on state of the model, including the synchronizer history seen as all-high
   function automatic void modelReset();
      for (int i = 0; i < 2; i++) begin
         mMode[i]      = "idle";
         mSel[i]       = 1'b0;
         mLocked[i]    = 1'b0;
         mPending[i]   = 1'b0;
         mColl[i]      = 0;
         mGuardLeft[i] = 0;
         mBusyEdges[i] = 0;
      end
      for (int k = 0; k < 3; k++) begin
         intHist[k] = 1'b1;
         extHist[k] = 1'b1;
      end
   endfunction

   function automatic void modelBump(input int i);
      if (mColl[i] < 255) mColl[i] = mColl[i] + 1;
   endfunction

   // A frame starts for the current owner; an external-owned frame makes the sticky instance lock
   function automatic void modelEnterBusy(input int i);
      mMode[i]      = "busy";
      mBusyEdges[i] = 0;
      if (i == 0 && mSel[i]) mLocked[i] = 1'b1;
   endfunction

   function automatic void modelEnterGuard(input int i);
      mMode[i]      = "guard";
      mGuardLeft[i] = GuardCycles;
      mPending[i]   = 1'b0;
   endfunction

   // One clock edge of arbitration rules for instance i, given the edges the core side can see
   function automatic void stepOne(input int i, input bit intFall, input bit intRise,
                                   input bit extFall, input bit extRise,
                                   input bit intLow, input bit extLow);
      bit ownFall, ownRise, ownLow, otherFall, otherIsInt, otherCounts;
      ownFall     = mSel[i] ? extFall : intFall;
      ownRise     = mSel[i] ? extRise : intRise;
      ownLow      = mSel[i] ? extLow  : intLow;
      otherFall   = mSel[i] ? intFall : extFall;
      otherIsInt  = mSel[i];
      otherCounts = otherFall && !(mLocked[i] && otherIsInt);

      if (mMode[i] == "idle") begin
         if (ownFall) begin
            if (otherCounts) modelBump(i);
            modelEnterBusy(i);
         end else if (otherCounts) begin
            mSel[i] = !mSel[i];
            modelEnterBusy(i);
         end
      end else if (mMode[i] == "busy") begin
         if (otherCounts) modelBump(i);
         mBusyEdges[i] = mBusyEdges[i] + 1;
         if (ownRise) modelEnterGuard(i);
         else if (mBusyEdges[i] == TimeoutCycles) mMode[i] = "lockout";
      end else if (mMode[i] == "guard") begin
         if (otherCounts) modelBump(i);
         if (ownFall) mPending[i] = 1'b1;
         mGuardLeft[i] = mGuardLeft[i] - 1;
         if (mGuardLeft[i] == 0) begin
            if (mPending[i] && ownLow) modelEnterBusy(i);
            else mMode[i] = "idle";
            mPending[i] = 1'b0;
         end
      end else begin
         if (otherCounts) modelBump(i);
         if (ownRise) modelEnterGuard(i);
      end
   endfunction

   // Derive what the core side sees (csn delayed two edges) and advance both models
   function automatic void modelStep();
      bit intFall, intRise, extFall, extRise;
      intFall = intHist[2] && !intHist[1];
      intRise = !intHist[2] && intHist[1];
      extFall = extHist[2] && !extHist[1];
      extRise = !extHist[2] && extHist[1];
      for (int i = 0; i < 2; i++) begin
         stepOne(i, intFall, intRise, extFall, extRise, !intHist[1], !extHist[1]);
      end
      intHist[2] = intHist[1]; intHist[1] = intHist[0]; intHist[0] = intCsn;
      extHist[2] = extHist[1]; extHist[1] = extHist[0]; extHist[0] = extCsn;
   endfunction

   // Drive one cycle of pin activity; csn follows random frame/gap lengths when randomMode is set
   task automatic applyStimulus();
      bit drv [2];
      intSclk = 1'($urandom);
      intMosi = 1'($urandom);
      extSclk = 1'($urandom);
      extMosi = 1'($urandom);
      mcuMiso = 1'($urandom);
      mcuIntn = 1'($urandom);
      if (randomMode) begin
         for (int p = 0; p < 2; p++) begin
            if (lowLeft[p] > 0) begin
               drv[p] = 1'b0;
               lowLeft[p]--;
               if (lowLeft[p] == 0) gapLeft[p] = int'($urandom_range(1, 25));
            end else if (gapLeft[p] > 0) begin
               drv[p] = 1'b1;
               gapLeft[p]--;
            end else begin
               lowLeft[p] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(100, 130))
                                                         : int'($urandom_range(2, 40));
               drv[p] = 1'b0;
               lowLeft[p]--;
            end
         end
         intCsn = drv[0];
         extCsn = drv[1];
      end
   endtask

   // Compare every output of both instances against what the model says they should be now
   task automatic checkAll();
      for (int i = 0; i < 2; i++) begin
         logic expCsn;
         expCsn = (mMode[i] == "idle" || mMode[i] == "busy") ? (mSel[i] ? extCsn : intCsn) : 1'b1;
         checkOutput($sformatf("extSel[%0d]", i),     32'(extSel[i]),     32'(mSel[i]));
         checkOutput($sformatf("lockedExt[%0d]", i),  32'(lockedExt[i]),  32'(mLocked[i]));
         checkOutput($sformatf("collisions[%0d]", i), 32'(collisions[i]), 32'(mColl[i]));
         checkOutput($sformatf("mcuCsn[%0d]", i),     32'(mcuCsn[i]),     32'(expCsn));
         checkOutput($sformatf("mcuSclk[%0d]", i),    32'(mcuSclk[i]),    32'(mSel[i] ? extSclk : intSclk));
         checkOutput($sformatf("mcuMosi[%0d]", i),    32'(mcuMosi[i]),    32'(mSel[i] ? extMosi : intMosi));
         checkOutput($sformatf("intMiso[%0d]", i),    32'(intMiso[i]),    32'(mSel[i] ? 1'b1 : mcuMiso));
         checkOutput($sformatf("extMiso[%0d]", i),    32'(extMiso[i]),    32'(mSel[i] ? mcuMiso : 1'b1));
         checkOutput($sformatf("intIntn[%0d]", i),    32'(intIntn[i]),    32'(mLocked[i] ? 1'b1 : mcuIntn));
         checkOutput($sformatf("extIntn[%0d]", i),    32'(extIntn[i]),    32'(mcuIntn));
      end
   endtask

   // One full clock: drive at the falling edge, model at the rising edge, check just after it
   task automatic runCycle();
      @(negedge clk32);
      applyStimulus();
      @(posedge clk32);
      if (por) modelReset();
      else modelStep();
      #1;
      checkAll();
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must change before any clock edge
   task automatic pulsePor();
      #2;
      por = 1'b1;
      #1;
      modelReset();
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("porSel[%0d]", i),  32'(extSel[i]),    32'(1'b0));
         checkOutput($sformatf("porLock[%0d]", i), 32'(lockedExt[i]), 32'(1'b0));
         checkOutput($sformatf("porCsn[%0d]", i),  32'(mcuCsn[i]),    32'(intCsn));
      end
      checkAll();
      runCycle();
      por = 1'b0;
   endtask

   // Main sequence: reset, random traffic, then directed lockout / reset / saturation scenarios
   initial begin
      por        = 1'b1;
      intCsn     = 1'b1;
      extCsn     = 1'b1;
      intSclk    = 1'b0;
      intMosi    = 1'b0;
      extSclk    = 1'b0;
      extMosi    = 1'b0;
      mcuMiso    = 1'b1;
      mcuIntn    = 1'b1;
      randomMode = 1'b0;
      modelReset();
      repeat (2) runCycle();
      por = 1'b0;

      for (int p = 0; p < 2; p++) begin
         lowLeft[p] = 0;
         gapLeft[p] = int'($urandom_range(1, 20));
      end
      randomMode = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         runCycle();
         if (n == 1500) pulsePor();
      end

      // External frame with int idle, then reset while it is still in progress
      randomMode = 1'b0;
      intCsn = 1'b1;
      extCsn = 1'b1;
      repeat (12) runCycle();
      extCsn = 1'b0;
      repeat (8) runCycle();
      checkOutput("extOwns[0]", 32'(extSel[0]), 32'(1'b1));
      checkOutput("extOwns[1]", 32'(extSel[1]), 32'(1'b1));
      checkOutput("stickyLock", 32'(lockedExt[0]), 32'(1'b1));
      pulsePor();
      extCsn = 1'b1;
      repeat (10) runCycle();

      // Internal csn stuck low long enough to trip the watchdog
      intCsn = 1'b0;
      repeat (110) runCycle();
      checkOutput("lockoutCsn[0]", 32'(mcuCsn[0]), 32'(1'b1));
      checkOutput("lockoutCsn[1]", 32'(mcuCsn[1]), 32'(1'b1));
      repeat (90) runCycle();
      intCsn = 1'b1;
      repeat (12) runCycle();

      // Internal owns the link while external keeps trying: 300 dropped frames saturate the counter
      intCsn = 1'b0;
      repeat (6) runCycle();
      repeat (300) begin
         extCsn = 1'b0;
         repeat (2) runCycle();
         extCsn = 1'b1;
         repeat (2) runCycle();
      end
      checkOutput("collSat[0]", 32'(collisions[0]), 32'd255);
      checkOutput("collSat[1]", 32'(collisions[1]), 32'd255);
      intCsn = 1'b1;
      repeat (12) runCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
